simon_key_ctrl: RTL
===================

SIMON_KEY_CTRL -- requirements
Module: simon_key_ctrl

Interface
REQ-001 The block SHALL have one parameter: ROUNDS, default 32, the number of round keys expanded (legal range 5..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, which is asynchronous and active-high.
REQ-004 The block SHALL have port key_in, input, 64 bits: the master key, with k0=[15:0], k1=[31:16], k2=[47:32] and k3=[63:48].
REQ-005 The block SHALL have port start, input, 1 bit: a request to capture key_in and run the expansion.
REQ-006 The block SHALL have port busy, output, 1 bit: high while the expansion is running.
REQ-007 The block SHALL have port done, output, 1 bit: a one-cycle pulse when the last round key is written.
REQ-008 The block SHALL have port keys_ready, output, 1 bit: high when the key file holds a complete schedule.
REQ-009 The block SHALL have port rd_en, input, 1 bit: a round-key read request.
REQ-010 The block SHALL have port rd_idx, input, 5 bits: the index of the round key to read.
REQ-011 The block SHALL have port rk_out, output, 16 bits: the registered round-key read data.
REQ-012 The block SHALL have port rk_valid, output, 1 bit: high for one cycle while rk_out holds the data for the previous cycle's read.

Function
REQ-013 The state machine SHALL have exactly two states, IDLE and EXPAND.
REQ-014 In IDLE, a sampled start SHALL: write k0..k3 to key-file entries 0..3, load the 4-word window, clear keys_ready, set the round counter i=4, and enter EXPAND.
REQ-015 Each EXPAND cycle SHALL write key i computed as: t = ror(k[i-1],3) ^ k[i-3]; t = t ^ ror(t,1); k[i] = k[i-4] ^ t ^ 0xFFFC ^ z0[(i-4) mod 62]. The window then shifts and i increments.
REQ-016 z0 SHALL be the 62-bit constant 11111010001001010110000111001101111101000100101011000011100110, indexed from the leftmost bit (index 0 = leftmost).
REQ-017 The edge that writes key ROUNDS-1 SHALL set done=1 and keys_ready=1 and return the state machine to IDLE; done SHALL clear on the next edge.
REQ-018 Latency SHALL be exactly ROUNDS-4 cycles from the start-sampling edge to the done-setting edge (28 cycles for the default).
REQ-019 busy SHALL equal (state==EXPAND).
REQ-020 start SHALL be ignored while busy.
REQ-021 start on the same cycle as done SHALL be accepted as a new run, because the state is IDLE then.
REQ-022 A read (rd_en) SHALL be serviced in any state: rk_out = key_file[rd_idx] and rk_valid=1 on the next edge; with rd_en low, rk_valid=0 and rk_out holds its value.
REQ-023 A read with rd_idx >= ROUNDS SHALL return 0x0000 with rk_valid=1.
REQ-024 A read of entry i on the same edge that writes entry i SHALL return the old contents.
REQ-025 Arithmetic SHALL be 16-bit, with rotations modulo 16 and no carries.

Reset
REQ-026 When rst is asserted, the block SHALL immediately set state=IDLE, busy=0, done=0, keys_ready=0, rk_valid=0, rk_out=0x0000, i=0, and clear every key-file entry and window word to 0.
REQ-027 Reset asserted mid-EXPAND SHALL abort the run with no done pulse, and the first start after rst deasserts SHALL begin a fresh run.

Configuration
REQ-028 The macro SIMON_KS_ZEROIZE_EN SHALL control the zeroize feature.
REQ-029 With SIMON_KS_ZEROIZE_EN defined, the block SHALL add an input zeroize (1 bit); a sampled zeroize SHALL clear the key file, the window, keys_ready and done within one edge and force IDLE, aborting any run.
REQ-030 zeroize SHALL take priority over a simultaneous start or read; a read on that edge SHALL return 0x0000.
REQ-031 With SIMON_KS_ZEROIZE_EN not defined, the zeroize port and its logic SHALL be absent, and key material SHALL be cleared only by rst.

Verification
REQ-032 Scenario: key_in=0x1918_1110_0908_0100, start pulse -> busy high for 28 cycles; done pulses once; keys_ready=1; entries 0..4 = 0x0100, 0x0908, 0x1110, 0x1918, 0x71C3.
REQ-033 Scenario: after REQ-032, rd_en with rd_idx=4 -> next cycle rk_valid=1, rk_out=0x71C3; rd_idx=31 -> the reference-model key 31; rd_idx=31 with ROUNDS=20 -> 0x0000.
REQ-034 Scenario: start re-pulsed at cycle 10 of EXPAND -> ignored; done still lands at cycle 28 with unchanged results.
REQ-035 Scenario: rst asserted at cycle 15 of EXPAND -> outputs zero without waiting for a clock edge; no done pulse; a fresh start completes in 28 cycles.
REQ-036 Scenario: start asserted in the done cycle with a new key -> second run accepted; keys_ready low for 28 cycles, then high with the new schedule.
REQ-037 Scenario (SIMON_KS_ZEROIZE_EN defined): zeroize at cycle 5 of EXPAND together with rd_en -> state IDLE, rk_out=0x0000, all entries read back 0x0000.

Source files
------------

// File: rtl/simon_key_ctrl.sv
// simon_key_ctrl: SIMON32/64 key schedule expander with a readable round-key file (optional SIMON_KS_ZEROIZE_EN adds a zeroize input)
module simon_key_ctrl #(
  parameter int ROUNDS = 32
) (
  input  logic        clk,
  input  logic        rst,
`ifdef SIMON_KS_ZEROIZE_EN
  input  logic        zeroize,
`endif
  input  logic [63:0] key_in,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        keys_ready,
  input  logic        rd_en,
  input  logic [4:0]  rd_idx,
  output logic [15:0] rk_out,
  output logic        rk_valid
);
  typedef enum logic {IDLE, EXPAND} state_t;
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [4:0] LAST = 5'(ROUNDS - 1);
  state_t state;
  logic [4:0] i;
  logic [15:0] kf [ROUNDS];
  logic [15:0] w [4];
  logic [15:0] t0, t1, nk;
  assign busy = (state == EXPAND);
  // next round key from the window w[0]=k[i-4] .. w[3]=k[i-1]; z0 is taken MSB-first
  always_comb begin
    t0 = {w[3][2:0], w[3][15:3]} ^ w[1];
    t1 = t0 ^ {t0[0], t0[15:1]};
    nk = w[0] ^ t1 ^ 16'hFFFC ^ {15'd0, Z0[6'd61 - {1'b0, i - 5'd4}]};
  end
  // expansion state machine, key file and window
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      done <= 1'b0;
      keys_ready <= 1'b0;
      i <= '0;
      for (int k = 0; k < ROUNDS; k++) kf[k] <= '0;
      for (int k = 0; k < 4; k++) w[k] <= '0;
    end
`ifdef SIMON_KS_ZEROIZE_EN
    else if (zeroize) begin
      state <= IDLE;
      done <= 1'b0;
      keys_ready <= 1'b0;
      i <= '0;
      for (int k = 0; k < ROUNDS; k++) kf[k] <= '0;
      for (int k = 0; k < 4; k++) w[k] <= '0;
    end
`endif
    else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          for (int k = 0; k < 4; k++) begin
            kf[k] <= key_in[16*k +: 16];
            w[k] <= key_in[16*k +: 16];
          end
          keys_ready <= 1'b0;
          i <= 5'd4;
          state <= EXPAND;
        end
      end else begin
        kf[i] <= nk;
        w[0] <= w[1];
        w[1] <= w[2];
        w[2] <= w[3];
        w[3] <= nk;
        i <= i + 5'd1;
        if (i == LAST) begin
          done <= 1'b1;
          keys_ready <= 1'b1;
          state <= IDLE;
        end
      end
    end
  // registered read port; a same-edge write is not forwarded, so reads see old contents
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rk_out <= '0;
      rk_valid <= 1'b0;
    end
`ifdef SIMON_KS_ZEROIZE_EN
    else if (zeroize) begin
      rk_valid <= rd_en;
      if (rd_en) rk_out <= '0;
    end
`endif
    else begin
      rk_valid <= rd_en;
      if (rd_en) rk_out <= (32'(rd_idx) < ROUNDS) ? kf[rd_idx] : '0;
    end
endmodule
